// File: rtl/mult_pkg.sv
// Shared widths and the Baugh-Wooley correction constant for the signed array multiplier.
package mult_pkg;

    localparam int unsigned MULT_W = 6;
    localparam int unsigned PROD_W = 2 * MULT_W;

    localparam logic [PROD_W-1:0] BW_CORR = 12'b1000_0100_0000;

    typedef logic [MULT_W-1:0] opnd_t;
    typedef logic [PROD_W-1:0] prod_t;

    // Correction constant for any operand width: ones at bit w and bit 2w-1.
    function automatic logic [63:0] bw_corr(input int unsigned w);
        logic [63:0] c;
        c = '0;
        c[w] = 1'b1;
        c[2*w-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mult_fa.sv
// One-bit full adder, the building cell of the carry-save rows and the final ripple adder.
module mult_fa
    import mult_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/multiplier.sv
// Signed WIDTHxWIDTH Baugh-Wooley carry-save array multiplier with a registered product.
module multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic [2*WIDTH-1:0]   prdct
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [63:0] CORR_WIDE = bw_corr(WIDTH);
    localparam logic [PW-1:0] CORR = CORR_WIDE[PW-1:0];

    // Partial-product rows, one per multiplier bit, already shifted to their weight.
    logic [WIDTH-1:0][PW-1:0] pp_row;

    always_comb begin
        for (int j = 0; j < int'(WIDTH); j++) begin
            pp_row[j] = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                // Cross terms with exactly one sign bit carry negative weight: invert them.
                if ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)) begin
                    pp_row[j][i+j] = ~(X[i] & Y[j]);
                end else begin
                    pp_row[j][i+j] = X[i] & Y[j];
                end
            end
        end
    end

    // Carry-save accumulation: row 0 seeds the sum, the correction constant seeds the carry.
    logic [WIDTH-1:0][PW-1:0] sum_v;
    logic [WIDTH-1:0][PW-1:0] carry_v;

    assign sum_v[0]   = pp_row[0];
    assign carry_v[0] = CORR;

    for (genvar r = 1; r < WIDTH; r++) begin : g_row
        assign carry_v[r][0] = 1'b0;
        for (genvar b = 0; b < PW - 1; b++) begin : g_bit
            mult_fa u_fa (
                .a    (sum_v[r-1][b]),
                .b    (carry_v[r-1][b]),
                .cin  (pp_row[r][b]),
                .s    (sum_v[r][b]),
                .cout (carry_v[r][b+1])
            );
        end
        // Top bit needs no carry out: it would land beyond the product width.
        assign sum_v[r][PW-1] = sum_v[r-1][PW-1] ^ carry_v[r-1][PW-1] ^ pp_row[r][PW-1];
    end

    // Final ripple adder merges the redundant sum/carry pair.
    logic [PW-1:0] fsum;
    logic [PW-1:0] rc;

    assign rc[0] = 1'b0;

    for (genvar b = 0; b < PW - 1; b++) begin : g_final
        mult_fa u_fa (
            .a    (sum_v[WIDTH-1][b]),
            .b    (carry_v[WIDTH-1][b]),
            .cin  (rc[b]),
            .s    (fsum[b]),
            .cout (rc[b+1])
        );
    end

    assign fsum[PW-1] = sum_v[WIDTH-1][PW-1] ^ carry_v[WIDTH-1][PW-1] ^ rc[PW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdct <= '0;
        end else begin
            prdct <= fsum;
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed and exhaustive checks of the registered signed 6x6 multiplier.
module tb_multiplier;

    logic        clk;
    logic        rst_n;
    logic [5:0]  X;
    logic [5:0]  Y;
    logic [11:0] prdct;

    int passed;
    int total;

    multiplier #(
        .WIDTH (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .Y     (Y),
        .prdct (prdct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        X = 6'd5;
        Y = 6'd7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        total++;
        if (prdct !== 12'h023) begin
            $display("FAIL reset_prerun: got %h want %h", prdct, 12'h023);
        end else begin
            passed++;
        end
        // Assert reset mid-cycle; the register must clear with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (prdct !== 12'h000) begin
            $display("FAIL reset_async: got %h want %h", prdct, 12'h000);
        end else begin
            passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if (prdct !== 12'h000) begin
            $display("FAIL reset_hold: got %h want %h", prdct, 12'h000);
        end else begin
            passed++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (prdct !== 12'h023) begin
            $display("FAIL reset_release: got %h want %h", prdct, 12'h023);
        end else begin
            passed++;
        end
    endtask

    task automatic test_corners();
        logic [5:0]  cx [5];
        logic [5:0]  cy [5];
        logic [11:0] ce [5];
        cx[0] = 6'd0;   cy[0] = 6'h20; ce[0] = 12'h000;
        cx[1] = 6'h3F;  cy[1] = 6'h3F; ce[1] = 12'h001;
        cx[2] = 6'd31;  cy[2] = 6'd31; ce[2] = 12'h3C1;
        cx[3] = 6'h20;  cy[3] = 6'h20; ce[3] = 12'h400;
        cx[4] = 6'h20;  cy[4] = 6'd31; ce[4] = 12'hC20;
        for (int k = 0; k < 5; k++) begin
            X = cx[k];
            Y = cy[k];
            @(posedge clk);
            #1;
            total++;
            if (prdct !== ce[k]) begin
                $display("FAIL corner_%0d: X=%h Y=%h got %h want %h", k, cx[k], cy[k], prdct, ce[k]);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_unsigned_sweep();
        logic [11:0] exp_p;
        for (int i = 0; i < 1024; i++) begin
            X = {1'b0, i[4:0]};
            Y = {1'b0, i[9:5]};
            exp_p = 12'(int'(i[4:0]) * int'(i[9:5]));
            @(posedge clk);
            #1;
            total++;
            if (prdct !== exp_p) begin
                $display("FAIL unsigned_sweep: X=%0d Y=%0d got %0d want %0d", X, Y, prdct, exp_p);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0]  xv;
        logic [5:0]  yv;
        int          xs;
        int          ys;
        logic [11:0] exp_p;
        for (int i = 0; i < 4096; i++) begin
            xv = i[5:0];
            yv = i[11:6];
            xs = int'($signed(xv));
            ys = int'($signed(yv));
            exp_p = 12'(xs * ys);
            X = xv;
            Y = yv;
            @(posedge clk);
            #1;
            total++;
            if (prdct !== exp_p) begin
                $display("FAIL exhaustive: X=%0d Y=%0d got %h want %h", xs, ys, prdct, exp_p);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                X = 6'd31;
                Y = 6'h3F;
            end else begin
                X = 6'h3E;
                Y = 6'h3D;
            end
            @(posedge clk);
            #1;
            total++;
            if (k % 2 == 0) begin
                if (prdct !== 12'hFE1) begin
                    $display("FAIL back_to_back_%0d: got %h want %h", k, prdct, 12'hFE1);
                end else begin
                    passed++;
                end
            end else begin
                if (prdct !== 12'h006) begin
                    $display("FAIL back_to_back_%0d: got %h want %h", k, prdct, 12'h006);
                end else begin
                    passed++;
                end
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        X      = '0;
        Y      = '0;
        #1;
        test_reset();
        test_corners();
        test_unsigned_sweep();
        test_exhaustive();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
